// File: rtl/pixel_stream_pkg.sv
// Shared types and counter-width helpers for the pixel-stream transmitter.
package pixel_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        ACTIVE,
        HBLANK,
        VBLANK
    } tx_state_t;

    function automatic int row_cnt_w(input int rows);
        return $clog2(rows);
    endfunction

    function automatic int beat_cnt_w(input int cols, input int pixcnt);
        return $clog2(cols / pixcnt + 1);
    endfunction

endpackage

// File: rtl/stream_blank_timer.sv
// Loadable down-counter shared by horizontal and vertical blanking.
// done_o is high during the last cycle of a loaded count (load N -> N cycles).
module stream_blank_timer
    import pixel_stream_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default assignment first, so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame-timing transmitter: pulls pixel words from a ready/valid source and
// emits rowSize lines of colSize/PIXCNT beats with programmable blanking.
module pixel_stream_tx
    import pixel_stream_pkg::*;
#(
    parameter int DWIDTH  = 10,
    parameter int PIXCNT  = 8,
    parameter int ROWS    = 2048,
    parameter int COLS    = 2448,
    parameter int BLANK_W = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [$clog2(ROWS)-1:0]   rowSize,
    input  logic [$clog2(COLS)-1:0]   colSize,
    input  logic [BLANK_W-1:0]        hblank,
    input  logic [BLANK_W-1:0]        vblank,
    input  logic [DWIDTH*PIXCNT-1:0]  src_data,
    input  logic                      src_vld,
    output logic                      src_rdy,
    output logic                      new_frame,
    output logic [DWIDTH*PIXCNT-1:0]  data_out,
    output logic                      data_vld,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      underrun
);

    localparam int ROW_W  = row_cnt_w(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int BEAT_W = beat_cnt_w(COLS, PIXCNT);
    localparam int PIX_SH = $clog2(PIXCNT);
    localparam int TMR_W  = BLANK_W + 1;

    tx_state_t                 state_q;
    logic [ROW_W-1:0]          rows_q, row_cnt_q;
    logic [BEAT_W-1:0]         bpl_q, col_cnt_q;
    logic [BLANK_W-1:0]        hblank_q, vblank_q;
    logic [DWIDTH*PIXCNT-1:0]  data_out_q;
    logic                      src_rdy_q, new_frame_q, data_vld_q;
    logic                      busy_q, frame_done_q, underrun_q;

    logic [COL_W-1:0]          col_beats;
    logic                      start_ok, hs, last_beat, last_row, line_end;
    logic                      tmr_load, tmr_done;
    logic [TMR_W-1:0]          tmr_value;

    assign col_beats = colSize >> PIX_SH;
    assign start_ok  = start && !abort && (rowSize != '0) && (col_beats != '0);
    assign hs        = src_vld && src_rdy_q;
    assign last_beat = (col_cnt_q == bpl_q - BEAT_W'(1));
    assign last_row  = (row_cnt_q == rows_q - ROW_W'(1));
    assign line_end  = (state_q == ACTIVE) && hs && last_beat;

    // Vertical blanking loads one extra count so frame_done lands in a final VBLANK cycle.
    assign tmr_load  = abort || line_end;
    always_comb begin
        tmr_value = '0;
        if (!abort) begin
            if (last_row) begin
                tmr_value = (vblank_q == '0) ? TMR_W'(2) : TMR_W'(vblank_q) + TMR_W'(1);
            end else begin
                tmr_value = TMR_W'(hblank_q);
            end
        end
    end

    stream_blank_timer #(.W(TMR_W)) u_blank_timer (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .done_o  (tmr_done)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            rows_q       <= '0;
            row_cnt_q    <= '0;
            bpl_q        <= '0;
            col_cnt_q    <= '0;
            hblank_q     <= '0;
            vblank_q     <= '0;
            data_out_q   <= '0;
            src_rdy_q    <= 1'b0;
            new_frame_q  <= 1'b0;
            data_vld_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register sees pre-edge values of the others.
            new_frame_q  <= 1'b0;
            frame_done_q <= 1'b0;
            data_vld_q   <= 1'b0;
            if (abort) begin
                state_q   <= IDLE;
                src_rdy_q <= 1'b0;
                busy_q    <= 1'b0;
                row_cnt_q <= '0;
                col_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_ok) begin
                            rows_q      <= rowSize;
                            bpl_q       <= BEAT_W'(col_beats);
                            hblank_q    <= hblank;
                            vblank_q    <= vblank;
                            underrun_q  <= 1'b0;
                            new_frame_q <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= SOF;
                        end
                    end
                    SOF: begin
                        src_rdy_q <= 1'b1;
                        state_q   <= ACTIVE;
                    end
                    ACTIVE: begin
                        if (hs) begin
                            data_out_q <= src_data;
                            data_vld_q <= 1'b1;
                            if (last_beat) begin
                                col_cnt_q <= '0;
                                if (last_row) begin
                                    row_cnt_q <= '0;
                                    src_rdy_q <= 1'b0;
                                    state_q   <= VBLANK;
                                end else begin
                                    row_cnt_q <= row_cnt_q + ROW_W'(1);
                                    if (hblank_q != '0) begin
                                        src_rdy_q <= 1'b0;
                                        state_q   <= HBLANK;
                                    end
                                end
                            end else begin
                                col_cnt_q <= col_cnt_q + BEAT_W'(1);
                            end
                        end else begin
                            underrun_q <= 1'b1;
                        end
                    end
                    HBLANK: begin
                        if (tmr_done) begin
                            src_rdy_q <= 1'b1;
                            state_q   <= ACTIVE;
                        end
                    end
                    VBLANK: begin
                        if (frame_done_q) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else if (tmr_done) begin
                            frame_done_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign src_rdy    = src_rdy_q;
    assign new_frame  = new_frame_q;
    assign data_out   = data_out_q;
    assign data_vld   = data_vld_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Self-checking bench for pixel_stream_tx: table of frame scenarios, each
// compared against a timeline model built from the frame-timing rules.
`timescale 1ns/1ps
module tb_pixel_stream_tx;

    localparam int DWIDTH  = 10;
    localparam int PIXCNT  = 8;
    localparam int ROWS    = 2048;
    localparam int COLS    = 2448;
    localparam int BLANK_W = 16;
    localparam int DW      = DWIDTH * PIXCNT;
    localparam int MAXC    = 400;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [10:0]         rowSize = '0;
    logic [11:0]         colSize = '0;
    logic [BLANK_W-1:0]  hblank = '0;
    logic [BLANK_W-1:0]  vblank = '0;
    logic [DW-1:0]       src_data = '0;
    logic                src_vld = 1'b0;
    logic                src_rdy, new_frame, data_vld, busy, frame_done, underrun;
    logic [DW-1:0]       data_out;

    always #5 sys_clk = ~sys_clk;

    pixel_stream_tx #(
        .DWIDTH(DWIDTH), .PIXCNT(PIXCNT), .ROWS(ROWS), .COLS(COLS), .BLANK_W(BLANK_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .abort      (abort),
        .rowSize    (rowSize),
        .colSize    (colSize),
        .hblank     (hblank),
        .vblank     (vblank),
        .src_data   (src_data),
        .src_vld    (src_vld),
        .src_rdy    (src_rdy),
        .new_frame  (new_frame),
        .data_out   (data_out),
        .data_vld   (data_vld),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " src_rdy"},    int'(src_rdy), 0);
        check({tag, " new_frame"},  int'(new_frame), 0);
        check({tag, " data_vld"},   int'(data_vld), 0);
        check({tag, " busy"},       int'(busy), 0);
        check({tag, " frame_done"}, int'(frame_done), 0);
        check({tag, " underrun"},   int'(underrun), 0);
        check_word({tag, " data_out"}, data_out, '0);
    endtask

    // Source word i carries pixels i*PIXCNT .. i*PIXCNT+PIXCNT-1.
    function automatic logic [DW-1:0] word_of(input int i);
        logic [DW-1:0] w;
        for (int k = 0; k < PIXCNT; k++) begin
            w[k*DWIDTH +: DWIDTH] = DWIDTH'(i * PIXCNT + k);
        end
        return w;
    endfunction

    typedef struct {
        int rows;
        int cols;
        int hb;
        int vb;
        int vld_mode;      // 0 always valid, 1 toggling 1,0, 2 random
        int abort_at;      // cycle to assert abort, 0 = none
        int start_at;      // extra start pulse while busy, 0 = none
        bit start_at_fd;   // pulse start in the frame_done cycle
        int exp_beats;
        int exp_nf;
        int exp_done_lat;  // cycles from last data_vld to frame_done, -1 = none
    } vec_t;

    vec_t vecs[$];
    bit   vld_arr[MAXC];

    // Timeline model. Cycle 0 drives start; new_frame is cycle 1; the source is offered
    // ready from cycle 2; each beat shows up one cycle after its handshake.
    int exp_dv[$];
    int exp_fd;
    int exp_rdy;
    int exp_und;

    task automatic model(input vec_t v);
        int rdy_cyc[$];
        int hs_cyc[$];
        int und_cyc[$];
        int bpl;
        int t;
        exp_dv.delete();
        exp_fd  = -1;
        exp_rdy = 0;
        exp_und = 0;
        bpl = v.cols / PIXCNT;
        if (v.rows == 0 || bpl == 0) return;
        t = 2;
        for (int r = 0; r < v.rows; r++) begin
            for (int b = 0; b < bpl; b++) begin
                while (!vld_arr[t] && t < MAXC - 1) begin
                    rdy_cyc.push_back(t);
                    und_cyc.push_back(t);
                    t++;
                end
                rdy_cyc.push_back(t);
                hs_cyc.push_back(t);
                t++;
            end
            if (r != v.rows - 1) t += v.hb;
        end
        exp_fd = hs_cyc[hs_cyc.size()-1] + 1 + ((v.vb == 0) ? 1 : v.vb) + 1;
        if (v.abort_at != 0) begin
            exp_fd  = -1;
            hs_cyc  = hs_cyc.find(x) with (x < v.abort_at);
            rdy_cyc = rdy_cyc.find(x) with (x <= v.abort_at);
            und_cyc = und_cyc.find(x) with (x < v.abort_at);
        end
        foreach (hs_cyc[i]) exp_dv.push_back(hs_cyc[i] + 1);
        exp_rdy = rdy_cyc.size();
        exp_und = (und_cyc.size() != 0) ? 1 : 0;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int dv_cyc[$];
        logic [DW-1:0] dv_word[$];
        int nf_cnt = 0, nf_cyc = -1, fd_cnt = 0, fd_cyc = -1;
        int rdy_cnt = 0, busy_hi = 0, src_idx = 0, run_len, n;
        for (int t = 0; t < MAXC; t++) begin
            case (v.vld_mode)
                0:       vld_arr[t] = 1'b1;
                1:       vld_arr[t] = (t % 2 == 0);
                default: vld_arr[t] = ($urandom_range(0, 3) != 0);
            endcase
        end
        model(v);
        run_len = (exp_fd > 0) ? exp_fd + 6 : ((v.abort_at != 0) ? v.abort_at + 20 : 25);

        @(negedge sys_clk);
        rowSize  = 11'(v.rows);
        colSize  = 12'(v.cols);
        hblank   = BLANK_W'(v.hb);
        vblank   = BLANK_W'(v.vb);
        start    = 1'b1;
        abort    = 1'b0;
        src_vld  = 1'b0;
        src_data = word_of(0);
        for (int t = 1; t <= run_len; t++) begin
            @(negedge sys_clk);
            if (new_frame)  begin nf_cnt++; nf_cyc = t; end
            if (frame_done) begin fd_cnt++; fd_cyc = t; end
            if (data_vld)   begin dv_cyc.push_back(t); dv_word.push_back(data_out); end
            if (src_rdy)    rdy_cnt++;
            if (busy)       busy_hi++;
            if (v.abort_at != 0 && t == v.abort_at + 1) begin
                check({tag, " busy after abort"},     int'(busy), 0);
                check({tag, " src_rdy after abort"},  int'(src_rdy), 0);
                check({tag, " data_vld after abort"}, int'(data_vld), 0);
            end
            if (exp_fd > 0 && t == exp_fd + 1) check({tag, " busy after done"}, int'(busy), 0);
            // Later configuration changes must not affect the running frame.
            rowSize  = 11'($urandom_range(1, 7));
            colSize  = 12'($urandom_range(8, 64));
            hblank   = BLANK_W'($urandom_range(0, 9));
            vblank   = BLANK_W'($urandom_range(0, 9));
            start    = (t == v.start_at) || (v.start_at_fd && t == exp_fd);
            abort    = (v.abort_at != 0 && t == v.abort_at);
            src_vld  = vld_arr[t];
            src_data = word_of(src_idx);
            if (src_vld && src_rdy) src_idx++;
        end
        start   = 1'b0;
        abort   = 1'b0;
        src_vld = 1'b0;

        check({tag, " new_frame count"}, nf_cnt, v.exp_nf);
        check({tag, " beat count"}, dv_cyc.size(), v.exp_beats);
        check({tag, " beat count model"}, dv_cyc.size(), exp_dv.size());
        check({tag, " src_rdy cycles"}, rdy_cnt, exp_rdy);
        if (v.exp_nf != 0) begin
            check({tag, " new_frame cycle"}, nf_cyc, 1);
            check({tag, " underrun"}, int'(underrun), exp_und);
        end else begin
            check({tag, " busy cycles"}, busy_hi, 0);
        end
        n = (dv_cyc.size() < exp_dv.size()) ? dv_cyc.size() : exp_dv.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s beat%0d cycle", tag, i), dv_cyc[i], exp_dv[i]);
            check_word($sformatf("%s beat%0d data", tag, i), dv_word[i], word_of(i));
        end
        if (v.exp_done_lat >= 0) begin
            check({tag, " frame_done count"}, fd_cnt, 1);
            check({tag, " frame_done cycle"}, fd_cyc, exp_fd);
            if (dv_cyc.size() != 0)
                check({tag, " done latency"}, fd_cyc - dv_cyc[dv_cyc.size()-1], v.exp_done_lat);
        end else begin
            check({tag, " frame_done count"}, fd_cnt, 0);
        end
    endtask

    initial begin
        //               rows cols hb vb mode abort st fd beats nf lat
        vecs.push_back('{2, 32, 3, 5, 0, 0,  0, 0, 8,  1, 6});   // basic frame
        vecs.push_back('{1, 64, 2, 1, 1, 0,  0, 0, 8,  1, 2});   // source gaps
        vecs.push_back('{3, 16, 0, 0, 0, 0,  0, 0, 6,  1, 2});   // zero blanking
        vecs.push_back('{2, 32, 3, 5, 0, 11, 0, 0, 6,  1, -1});  // abort on 3rd beat of row 1
        vecs.push_back('{2, 32, 3, 5, 0, 0,  4, 0, 8,  1, 6});   // fresh frame, start while busy
        vecs.push_back('{0, 32, 3, 5, 0, 0,  0, 0, 0,  0, -1});  // rowSize 0
        vecs.push_back('{2, 4,  3, 5, 0, 0,  0, 0, 0,  0, -1});  // colSize below one beat
        vecs.push_back('{3, 40, 2, 3, 2, 0,  0, 1, 15, 1, 4});   // random source, start at frame_done
        vecs.push_back('{2, 21, 1, 0, 2, 0,  0, 0, 4,  1, 2});   // colSize low bits ignored
        vecs.push_back('{4, 24, 5, 2, 2, 0,  0, 0, 12, 1, 3});   // random source

        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        sys_rst_n = 1'b1;

        foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of ACTIVE.
        @(negedge sys_clk);
        rowSize  = 11'd2;
        colSize  = 12'd32;
        hblank   = BLANK_W'(3);
        vblank   = BLANK_W'(5);
        start    = 1'b1;
        src_vld  = 1'b1;
        src_data = word_of(0);
        @(negedge sys_clk);
        start = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("areset precondition src_rdy", int'(src_rdy), 1);
        #2 sys_rst_n = 1'b0;
        #1 check_all_zero("areset");
        src_vld = 1'b0;
        repeat (2) @(negedge sys_clk);
        check_all_zero("areset held");
        sys_rst_n = 1'b1;
        run_frame(vecs[0], "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_stream_tx.md
Name: pixel_stream_tx

Overview:
- Frame-timing transmitter that drives the pixel-stream interface consumed by the filter pipeline: new_frame, data_in, data_vld, rowSize, colSize.
- Pulls PIXCNT-pixel words from an upstream ready/valid source, such as a frame-buffer reader FIFO.
- Emits exactly rowSize lines of colSize/PIXCNT beats each.
- Inserts programmable horizontal and vertical blanking so downstream line buffers can flush between lines and frames.

Parameters:
- DWIDTH, 10, bits per pixel
- PIXCNT, 8, pixels per beat
- ROWS, 2048, maximum rows per frame
- COLS, 2448, maximum columns per frame
- BLANK_W, 16, width of blanking-length inputs

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; starts one frame; sampled only in IDLE
- abort  in  1  synchronous abort of the current frame
- rowSize  in  $clog2(ROWS)  rows per frame; latched on accepted start
- colSize  in  $clog2(COLS)  pixels per line; latched on accepted start; must be a multiple of PIXCNT (low bits ignored)
- hblank  in  BLANK_W  idle cycles between lines; latched on start
- vblank  in  BLANK_W  idle cycles after the last line; latched on start
- src_data  in  DWIDTH*PIXCNT  upstream pixel word
- src_vld  in  1  upstream valid
- src_rdy  out  1  ready to upstream
- new_frame  out  1  one-cycle frame-start pulse
- data_out  out  DWIDTH*PIXCNT  pixel word to the filter
- data_vld  out  1  data_out qualifier
- busy  out  1  high whenever state is not IDLE
- frame_done  out  1  one-cycle pulse at normal frame end
- underrun  out  1  sticky: src_vld was low while src_rdy was high inside a line; cleared on accepted start

Behaviour:
- Reset: all outputs 0, data_out 0, state IDLE, all counters 0. Every output is registered.
- Beats per line: BPL = colSize >> $clog2(PIXCNT).
- Start is accepted only when all of the following hold; otherwise it is ignored, with no output change:
  - state is IDLE
  - rowSize != 0
  - BPL != 0
- States and transitions:
  - IDLE: on accepted start, latch the configuration, clear underrun, go to SOF.
  - SOF: lasts one cycle; new_frame=1; go to ACTIVE.
  - ACTIVE: src_rdy=1.
    - On each src_vld&src_rdy, register src_data into data_out with data_vld=1 in the next cycle, and increment col_cnt.
    - A cycle without a handshake gives data_vld=0 next cycle and sets underrun.
    - On the handshake with col_cnt==BPL-1: clear col_cnt, and drop src_rdy in the next cycle.
      - If row_cnt==rowSize-1: go to VBLANK.
      - Else: increment row_cnt and go to HBLANK, or straight back to ACTIVE if hblank==0.
  - HBLANK: src_rdy=0; hold for hblank cycles; then ACTIVE.
  - VBLANK: src_rdy=0; hold for vblank cycles (vblank==0 means 1 cycle); then frame_done=1 for one cycle and go to IDLE.
- Latency:
  - Start sampled at edge k gives new_frame high during cycle k+1.
  - src_rdy goes high from cycle k+2.
  - Each beat reaches data_out one cycle after its handshake.
- Beat count: the frame carries exactly rowSize*BPL data_vld beats; src_rdy is never high outside ACTIVE.
- abort in any non-IDLE state:
  - Next cycle: IDLE, src_rdy=0, data_vld=0; the last in-flight beat is dropped.
  - No frame_done. Counters are cleared.
  - abort has priority over start in the same cycle.
- Configuration inputs changing mid-frame have no effect, because the frame uses the latched copies.
- Asynchronous reset mid-frame: immediate return to the reset state; no new_frame or frame_done pulse is generated.
- start in the same cycle as frame_done (state still VBLANK) is ignored. start is accepted from the first IDLE cycle onward.

Decomposition:
- Package pixel_stream_pkg holds:
  - typedef enum {IDLE, SOF, ACTIVE, HBLANK, VBLANK} tx_state_t
  - localparam functions for counter widths: row counter $clog2(ROWS), beat counter $clog2(COLS/PIXCNT+1)
- One sub-module, stream_blank_timer: a loadable down-counter with a done pulse, shared by HBLANK and VBLANK.

Test Plan:
- Basic frame: PIXCNT=8, colSize=32, rowSize=2, hblank=3, vblank=5, src_vld tied 1.
  - new_frame pulses once.
  - 8 data_vld beats, in groups of 4, with exactly 3 idle cycles between the groups.
  - frame_done comes 6 cycles after the last data_vld.
  - underrun stays 0.
- Source gaps: src_vld toggling 1,0 inside a line.
  - data_vld shows matching gaps.
  - data_out word order is preserved (incrementing pattern 0..7).
  - underrun reads 1 after the frame.
- Zero blanking: hblank=0, rowSize=3, colSize=16.
  - 6 contiguous data_vld beats with no gaps.
  - frame_done follows 2 cycles after the last beat.
- Abort mid-line: assert abort on the 3rd beat of row 1.
  - busy=0 and src_rdy=0 next cycle; no frame_done.
  - A following start produces a correct fresh frame.
- Illegal config and busy start:
  - rowSize=0 start, and colSize=4 start with PIXCNT=8: no new_frame, busy stays 0.
  - start pulsed during ACTIVE: ignored, and the beat count is unchanged.
- Asynchronous reset: drop sys_rst_n mid-ACTIVE, with no clock edge needed.
  - All outputs go to 0 immediately.
  - After release, the next start behaves as in the basic-frame scenario.
